// File: rtl/stream_pool2x2_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_pool2x2_if
//  Brief    : Input and output valid/ready stream bundle for stream_pool2x2.
//             The slave modport is the pooling engine's view. The master
//             modport is the view of the environment that feeds it and
//             drains it.
//  Revision : 1.0  initial release
// ============================================================================
interface stream_pool2x2_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface
`default_nettype wire

// File: rtl/stream_pool2x2.sv
`default_nettype none
// ============================================================================
//  Module   : stream_pool2x2
//  Brief    : Streaming 2x2 / stride-2 max or average pooling over raster-order
//             pixels. The engine has CHANNELS independent lanes and uses one
//             half-width line buffer. Trailing odd rows and columns are dropped.
//  Revision : 1.0  initial release
// ============================================================================
module stream_pool2x2 #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 1,
  parameter int IFMAP_HEIGHT = 510,
  parameter int IFMAP_WIDTH  = 510
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       en,
  input  wire logic       mode,
  stream_pool2x2_if.slave bus,
  output logic            busy,
  output logic            done_pool
);

  localparam int c_row_w    = $clog2(IFMAP_HEIGHT);
  localparam int c_col_w    = $clog2(IFMAP_WIDTH);
  localparam int c_lb_depth = IFMAP_WIDTH / 2;
  localparam int c_lb_w     = (c_lb_depth > 1) ? $clog2(c_lb_depth) : 1;
  localparam bit c_odd_w    = (IFMAP_WIDTH % 2) != 0;
  localparam bit c_odd_h    = (IFMAP_HEIGHT % 2) != 0;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]                     r_state;
  logic [1:0]                     w_state_next;
  logic [c_row_w-1:0]             r_row;
  logic [c_col_w-1:0]             r_col;
  logic                           r_mode;
  logic                           r_m_valid;
  logic                           r_m_last;
  logic [CHANNELS*DATA_WIDTH-1:0] r_m_data;
  logic [CHANNELS*DATA_WIDTH-1:0] w_out_all;
  logic                           w_s_ready;
  logic                           w_acc;
  logic                           w_col_end;
  logic                           w_final_px;
  logic                           w_col_keep;
  logic                           w_row_keep;
  logic                           w_load;
  logic                           w_load_last;
  logic [c_lb_w-1:0]              w_lb_idx;

  assign w_acc      = bus.s_valid && w_s_ready;
  assign w_col_end  = (r_col == c_col_w'(IFMAP_WIDTH - 1));
  assign w_final_px = w_col_end && (r_row == c_row_w'(IFMAP_HEIGHT - 1));
  // A trailing odd column or row is consumed but does not take part in any window.
  assign w_col_keep = !(c_odd_w && w_col_end);
  assign w_row_keep = !(c_odd_h && (r_row == c_row_w'(IFMAP_HEIGHT - 1)));
  assign w_lb_idx   = c_lb_w'(r_col >> 1);
  // The bottom-right pixel of a 2x2 window completes one pooled output.
  assign w_load     = w_acc && w_col_keep && w_row_keep && r_col[0] && r_row[0];
  assign w_load_last = (r_row == c_row_w'(2 * (IFMAP_HEIGHT / 2) - 1)) &&
                       (r_col == c_col_w'(2 * (IFMAP_WIDTH / 2) - 1));

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_last  = r_m_last;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  // Next-state logic: DRAIN waits until the last pooled beat has left the output register
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:  if (en) w_state_next = c_st_run;
      c_st_run:   if (w_acc && w_final_px) w_state_next = c_st_drain;
      c_st_drain: if (!r_m_valid || bus.m_ready) w_state_next = c_st_done;
      c_st_done:  w_state_next = c_st_idle;
      default:    w_state_next = c_st_idle;
    endcase
  end

  // State outputs: input is stalled while the single output stage is full
  always_comb begin
    w_s_ready = (r_state == c_st_run) && (!r_m_valid || bus.m_ready);
    busy      = (r_state == c_st_run) || (r_state == c_st_drain);
    done_pool = (r_state == c_st_done);
  end

  // Raster position counters and per-frame mode latch
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_mode <= 1'b0;
    end else if ((r_state == c_st_idle) && en) begin
      r_row  <= '0;
      r_col  <= '0;
      r_mode <= mode;
    end else if (w_acc) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + c_row_w'(1);
      end else begin
        r_col <= r_col + c_col_w'(1);
      end
    end
  end

  // Single-stage output register: load on window completion and hold until accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_load_last;
      r_m_data  <= w_out_all;
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  genvar k;
  for (k = 0; k < CHANNELS; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_px;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH:0]   r_lb [c_lb_depth];
    logic [DATA_WIDTH:0]   w_lb_rd;
    logic [DATA_WIDTH:0]   w_pair;
    logic [DATA_WIDTH+1:0] w_sum4;
    logic [DATA_WIDTH-1:0] w_res;

    assign w_px    = bus.s_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_lb_rd = r_lb[w_lb_idx];
    assign w_out_all[k*DATA_WIDTH +: DATA_WIDTH] = w_res;

    // Horizontal pair combine, then vertical combine against the line buffer
    always_comb begin
      w_pair = '0;
      w_sum4 = '0;
      w_res  = '0;
      if (r_mode) begin
        w_pair = {1'b0, r_hold} + {1'b0, w_px};
        w_sum4 = {1'b0, w_pair} + {1'b0, w_lb_rd};
        w_res  = DATA_WIDTH'(w_sum4 >> 2);
      end else begin
        w_pair = {1'b0, (w_px > r_hold) ? w_px : r_hold};
        w_res  = (w_pair[DATA_WIDTH-1:0] > w_lb_rd[DATA_WIDTH-1:0]) ?
                 w_pair[DATA_WIDTH-1:0] : w_lb_rd[DATA_WIDTH-1:0];
      end
    end

    // Even columns park in the hold register; on even rows, pair results fill the line buffer
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_hold <= '0;
        for (int i = 0; i < c_lb_depth; i++) r_lb[i] <= '0;
      end else if (w_acc && w_col_keep && w_row_keep) begin
        if (!r_col[0])     r_hold <= w_px;
        else if (!r_row[0]) r_lb[w_lb_idx] <= w_pair;
      end
    end
  end

endmodule
`default_nettype wire
